// File: rtl/slave_port.sv
// ---------------------------------------------------------------------------
// slave_port
//   Serial-bus target. Receives a read/write request from the master port as
//   a 1-bit stream (address LSB first, then write data LSB first for writes),
//   performs a single access on a local parallel memory interface and, for
//   reads, returns the data word serially LSB first.
//
//   Optional feature macro: SLAVE_SPLIT_EN
//     defined   : a wait counter runs while the memory read is pending and
//                 raises ssplit once SPLIT_CYCLES wait cycles have elapsed.
//     undefined : no wait counter, ssplit is tied low.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   swdata       serial address / write data from master
//   smode        0 read, 1 write; sampled with the first address bit
//   mvalid       swdata/smode valid this cycle
//   srdata       serial read data to master
//   svalid       srdata valid this cycle
//   sready       idle, a new transaction may start
//   ssplit       split request to arbiter
//   smemaddr     local memory address
//   smemwdata    local memory write data
//   smemwen      write strobe, one-cycle pulse
//   smemren      read request, held until smemrvalid
//   smemrdata    local memory read data
//   smemrvalid   smemrdata valid (only honoured while smemren=1)
// ---------------------------------------------------------------------------
module slave_port #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int SPLIT_CYCLES         = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            swdata,
  input  logic                            smode,
  input  logic                            mvalid,
  output logic                            srdata,
  output logic                            svalid,
  output logic                            sready,
  output logic                            ssplit,
  output logic [SLAVE_MEM_ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0]           smemwdata,
  output logic                            smemwen,
  output logic                            smemren,
  input  logic [DATA_WIDTH-1:0]           smemrdata,
  input  logic                            smemrvalid
);

  localparam int AW   = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int MAXW = (AW > DW) ? AW : DW;
  localparam int CW   = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] A_ONE     = AW'(1);
  localparam logic [DW-1:0] D_ONE     = DW'(1);

  // Elaboration-time parameter sanity checks.
  if (ADDR_WIDTH < SLAVE_MEM_ADDR_WIDTH) begin : g_bad_addr_width
    $error("slave_port: ADDR_WIDTH must be >= SLAVE_MEM_ADDR_WIDTH");
  end
  if (SPLIT_CYCLES < 1) begin : g_bad_split_cycles
    $error("slave_port: SPLIT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_MEMWR = 3'd3,
    S_MEMRD = 3'd4,
    S_RDATA = 3'd5
  } state_t;

  state_t        state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt, cnt_inc;
  logic          mode_r, mode_nxt;
  logic [AW-1:0] addr_sh_r, addr_sh_nxt, addr_ins, memaddr_nxt;
  logic [DW-1:0] data_sh_r, data_sh_nxt, data_ins, memwdata_nxt;
  logic [DW-1:0] rdata_r, rdata_nxt;
  logic          srdata_nxt;

  // Next-state and datapath decode for the transaction sequencer.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    mode_nxt     = mode_r;
    addr_sh_nxt  = addr_sh_r;
    data_sh_nxt  = data_sh_r;
    rdata_nxt    = rdata_r;
    memaddr_nxt  = smemaddr;
    memwdata_nxt = smemwdata;
    srdata_nxt   = 1'b0;
    cnt_inc      = cnt_r + CNT_ONE;
    // Replace bit [cnt_r] with the incoming serial bit (stale bits are overwritten).
    addr_ins     = (addr_sh_r & ~(A_ONE << cnt_r)) | (AW'(swdata) << cnt_r);
    data_ins     = (data_sh_r & ~(D_ONE << cnt_r)) | (DW'(swdata) << cnt_r);

    case (state_r)
      S_IDLE: begin
        if (mvalid) begin
          mode_nxt    = smode;
          addr_sh_nxt = addr_ins;
          if (cnt_r == ADDR_LAST) begin
            // Single-bit address: the whole address arrived with the first bit.
            memaddr_nxt = addr_ins;
            cnt_nxt     = '0;
            state_nxt   = smode ? S_WDATA : S_MEMRD;
          end else begin
            cnt_nxt   = cnt_inc;
            state_nxt = S_ADDR;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (mvalid) begin
          addr_sh_nxt = addr_ins;
          if (cnt_r == ADDR_LAST) begin
            memaddr_nxt = addr_ins;
            cnt_nxt     = '0;
            state_nxt   = mode_r ? S_WDATA : S_MEMRD;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = S_ADDR;
        end
      end
      S_WDATA: begin
        if (mvalid) begin
          data_sh_nxt = data_ins;
          if (cnt_r == DATA_LAST) begin
            memwdata_nxt = data_ins;
            cnt_nxt      = '0;
            state_nxt    = S_MEMWR;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = S_WDATA;
        end
      end
      S_MEMWR: begin
        state_nxt = S_IDLE;
      end
      S_MEMRD: begin
        if (smemrvalid) begin
          rdata_nxt  = smemrdata;
          srdata_nxt = smemrdata[0];
          cnt_nxt    = '0;
          state_nxt  = S_RDATA;
        end else begin
          state_nxt = S_MEMRD;
        end
      end
      S_RDATA: begin
        if (cnt_r == DATA_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          // srdata is registered, so present the bit for the following cycle.
          cnt_nxt    = cnt_inc;
          srdata_nxt = |(rdata_r & (D_ONE << cnt_inc));
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      mode_r    <= 1'b0;
      addr_sh_r <= '0;
      data_sh_r <= '0;
      rdata_r   <= '0;
      smemaddr  <= '0;
      smemwdata <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      sready    <= 1'b1;
      smemwen   <= 1'b0;
      smemren   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      mode_r    <= mode_nxt;
      addr_sh_r <= addr_sh_nxt;
      data_sh_r <= data_sh_nxt;
      rdata_r   <= rdata_nxt;
      smemaddr  <= memaddr_nxt;
      smemwdata <= memwdata_nxt;
      srdata    <= srdata_nxt;
      svalid    <= (state_nxt == S_RDATA);
      sready    <= (state_nxt == S_IDLE);
      smemwen   <= (state_nxt == S_MEMWR);
      smemren   <= (state_nxt == S_MEMRD);
    end
  end

`ifdef SLAVE_SPLIT_EN
  localparam int WW = $clog2(SPLIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(SPLIT_CYCLES);

  logic [WW-1:0] wait_r, wait_nxt;

  // Read-wait counter: zero outside MEMRD, saturates at SPLIT_CYCLES.
  always_comb begin
    wait_nxt = wait_r;
    if (state_r != S_MEMRD) begin
      wait_nxt = '0;
    end else if (!smemrvalid && (wait_r != WAIT_LIM)) begin
      wait_nxt = wait_r + WW'(1);
    end else begin
      wait_nxt = wait_r;
    end
  end

  // Split request register; drops as soon as the sequencer leaves MEMRD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_r <= '0;
      ssplit <= 1'b0;
    end else begin
      wait_r <= wait_nxt;
      ssplit <= (state_nxt == S_MEMRD) && (wait_nxt == WAIT_LIM);
    end
  end
`else
  assign ssplit = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port.sv
// ---------------------------------------------------------------------------
// tb_slave_port
//   Directed bench for slave_port. Stimulus tasks push the expected memory
//   writes and expected serial read words into queues; a negedge monitor pops
//   and compares whenever the DUT pulses smemwen or presents svalid bits.
// ---------------------------------------------------------------------------
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SPLIT_AT = 4;
`ifdef SLAVE_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          swdata, smode, mvalid;
  logic          srdata, svalid, sready, ssplit;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata;
  logic          smemwen, smemren;
  logic [DW-1:0] smemrdata;
  logic          smemrvalid;

  slave_port #(
    .ADDR_WIDTH(16), .DATA_WIDTH(DW), .SLAVE_MEM_ADDR_WIDTH(AW), .SPLIT_CYCLES(SPLIT_AT)
  ) dut (
    .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit),
    .smemaddr(smemaddr), .smemwdata(smemwdata), .smemwen(smemwen), .smemren(smemren),
    .smemrdata(smemrdata), .smemrvalid(smemrvalid)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int wr_target = 0;
  int rd_target = 0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares memory write strobes and serial read words against the queues.
  logic          prev_wen = 1'b0;
  logic [DW-1:0] rd_acc = '0;
  int            rd_cnt = 0;
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst) begin
      prev_wen = 1'b0;
      rd_cnt   = 0;
    end else begin
      if (smemwen) begin
        check("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
        if (exp_wr.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL wr_unexpected: smemwen with addr 0x%0h data 0x%0h, none expected", smemaddr, smemwdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", {20'd0, smemaddr}, {20'd0, e[AW+DW-1:DW]});
          check("wr_data", {24'd0, smemwdata}, {24'd0, e[DW-1:0]});
          wr_seen++;
        end
      end
      prev_wen = smemwen;
      if (svalid) begin
        if (rd_cnt == 0 && exp_rd.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rd_unexpected: svalid with srdata %0d, none expected", srdata);
        end else begin
          rd_acc[rd_cnt] = srdata;
          rd_cnt++;
          if (rd_cnt == DW) begin
            check("rd_data", {24'd0, rd_acc}, {24'd0, exp_rd.pop_front()});
            rd_cnt = 0;
            rd_seen++;
          end
        end
      end else if (rd_cnt != 0) begin
        check("rd_gap_bits", rd_cnt, 32'd0);
        rd_cnt = 0;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_sready"},  {31'd0, sready},  32'd1);
    check({tag, "_svalid"},  {31'd0, svalid},  32'd0);
    check({tag, "_srdata"},  {31'd0, srdata},  32'd0);
    check({tag, "_ssplit"},  {31'd0, ssplit},  32'd0);
    check({tag, "_smemwen"}, {31'd0, smemwen}, 32'd0);
    check({tag, "_smemren"}, {31'd0, smemren}, 32'd0);
    check({tag, "_smemaddr"},  {20'd0, smemaddr},  32'd0);
    check({tag, "_smemwdata"}, {24'd0, smemwdata}, 32'd0);
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!sready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, sready}, 32'd1);
  endtask

  // Shift n bits of v LSB first; with gaps, an idle cycle carrying junk precedes each bit.
  task automatic send_bits(input logic [31:0] v, input int n, input logic mode, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        mvalid = 1'b0;
        swdata = ~v[i];
        smode  = ~mode;
        @(negedge clk);
      end
      mvalid = 1'b1;
      swdata = v[i];
      smode  = mode;
      @(negedge clk);
    end
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit gaps);
    wait_ready("wr_start_ready");
    exp_wr.push_back({addr, data});
    wr_target++;
    send_bits({20'd0, addr}, AW, 1'b1, gaps);
    send_bits({24'd0, data}, DW, 1'b1, gaps);
    check("wr_busy_sready", {31'd0, sready}, 32'd0);
    wait_ready("wr_done_ready");
    check("wr_count", wr_seen, wr_target);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int delay);
    wait_ready("rd_start_ready");
    exp_rd.push_back(data);
    rd_target++;
    smemrdata = ~data;
    send_bits({20'd0, addr}, AW, 1'b0, 1'b0);
    check("rd_smemren_on", {31'd0, smemren}, 32'd1);
    check("rd_smemaddr", {20'd0, smemaddr}, {20'd0, addr});
    for (int k = 0; k < delay; k++) begin
      check("rd_ssplit_wait", {31'd0, ssplit}, {31'd0, (SPLIT_ON && k >= SPLIT_AT)});
      @(negedge clk);
    end
    check("rd_ssplit_accept", {31'd0, ssplit}, {31'd0, (SPLIT_ON && delay >= SPLIT_AT)});
    smemrvalid = 1'b1;
    smemrdata  = data;
    @(negedge clk);
    smemrvalid = 1'b0;
    smemrdata  = ~data;
    check("rd_smemren_off", {31'd0, smemren}, 32'd0);
    check("rd_ssplit_off",  {31'd0, ssplit},  32'd0);
    check("rd_svalid_on",   {31'd0, svalid},  32'd1);
    wait_ready("rd_done_ready");
    check("rd_count", rd_seen, rd_target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    swdata = 1'b0; smode = 1'b0; mvalid = 1'b0;
    smemrdata = '0; smemrvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of the write-data phase: no strobe may follow.
    send_bits(32'hA5C, AW, 1'b1, 1'b0);
    send_bits(32'h0D, 4, 1'b1, 1'b0);
    rst = 1'b1;
    mvalid = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_write", wr_seen, 32'd0);
    check("midrst_sready", {31'd0, sready}, 32'd1);

    // Plain write, then read with a two-cycle memory latency.
    do_write(12'hA5C, 8'h3D, 1'b0);
    do_read(12'h123, 8'hB6, 2);

    // smemrvalid while idle must be ignored.
    smemrvalid = 1'b1;
    smemrdata  = 8'hFF;
    repeat (3) @(negedge clk);
    smemrvalid = 1'b0;
    check("idle_rvalid_sready", {31'd0, sready}, 32'd1);
    check("idle_rvalid_smemren", {31'd0, smemren}, 32'd0);

    // Writes with idle gaps between every bit.
    do_write(12'hA5C, 8'h3D, 1'b1);
    do_write(12'h5A3, 8'hC2, 1'b1);

    // Long, short and threshold read latencies (split behaviour).
    do_read(12'h456, 8'h5A, 10);
    do_read(12'h789, 8'hE1, 2);
    do_read(12'hFFF, 8'h80, SPLIT_AT);

    // Back-to-back: read, then write starting the cycle sready returns.
    do_read(12'h0F0, 8'h69, 0);
    do_write(12'h00F, 8'h96, 1'b0);
    do_write(12'h000, 8'h01, 1'b0);

    repeat (4) @(negedge clk);
    check("final_wr_queue_empty", exp_wr.size(), 32'd0);
    check("final_rd_queue_empty", exp_rd.size(), 32'd0);
    check("final_sready", {31'd0, sready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
